// File: rtl/alu_srcb_pkg.sv
// Shared select encoding and default widths for the ALU operand-B stage.
package alu_srcb_pkg;

    typedef enum logic [2:0] {
        SEL_B        = 3'd0,
        SEL_PCINC    = 3'd1,
        SEL_SEXT     = 3'd2,
        SEL_SEXT_SL2 = 3'd3,
        SEL_ONE      = 3'd4,
        SEL_ZEXT     = 3'd5,
        SEL_UPPER    = 3'd6,
        SEL_RSVD     = 3'd7
    } sel_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IMM_W  = 16;
    localparam int DEF_PC_INC = 4;

endpackage

// File: rtl/alu_srcb_skid.sv
// Two-entry skid buffer: output register plus one skid register.
// in_ready is a flop that mirrors the next skid occupancy, so the upstream
// side never sees a combinational path from out_ready.
module alu_srcb_skid #(
    parameter int PW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_pay_q, out_pay_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_pay_q, skid_pay_d;
    logic          in_ready_q, in_ready_d;
    logic          accept;
    logic          load_out;

    // Next-state for both entries; the skid entry always has priority into the
    // output register so ordering is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pay_d    = out_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        accept       = in_valid && in_ready_q;
        load_out     = !out_valid_q || out_ready;

        if (load_out) begin
            if (skid_valid_q) begin
                // in_ready_q is low whenever skid is full, so no accept here.
                out_pay_d    = skid_pay_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_pay_d   = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_pay_d   = in_data;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset; reset discards both entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_pay_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pay_q    <= out_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_pay_q;

endmodule

// File: rtl/alu_srcb_stage.sv
// ALU operand-B select stage: combinational decode of the select code into a
// DATA_W operand, registered through a two-entry skid buffer, plus a sticky
// flag recording acceptance of the reserved select.
module alu_srcb_stage
    import alu_srcb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int PC_INC = DEF_PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel_err,
    input  logic              err_clr,
    output logic              err_sticky
);

    localparam int PW = DATA_W + 1;

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic [PW-1:0]     skid_out;
    logic              accept;
    logic              err_sticky_q, err_sticky_d;

    // Operand decode; shifts are done at DATA_W so overflow bits fall off.
    always_comb begin
        imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
        dec_data = '0;
        dec_err  = 1'b0;
        case (sel_e'(sel))
            SEL_B:        dec_data = b;
            SEL_PCINC:    dec_data = DATA_W'(PC_INC);
            SEL_SEXT:     dec_data = imm_sext;
            SEL_SEXT_SL2: dec_data = imm_sext << 2;
            SEL_ONE:      dec_data = DATA_W'(1);
            SEL_ZEXT:     dec_data = imm_zext;
            SEL_UPPER:    dec_data = {imm, {(DATA_W-IMM_W){1'b0}}};
            SEL_RSVD:     dec_err  = 1'b1;
            default:      dec_err  = 1'b1;
        endcase
    end

    alu_srcb_skid #(.PW(PW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_err, dec_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign out_sel_err = skid_out[DATA_W];
    assign out_data    = skid_out[DATA_W-1:0];

    // Sticky error next-state: a new reserved acceptance wins over a clear.
    always_comb begin
        accept       = in_valid && in_ready;
        err_sticky_d = err_sticky_q;
        if (accept && dec_err) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Directed bench for alu_srcb_stage: default 32-bit instance plus a 64-bit
// instance with PC_INC=8.
module tb_alu_srcb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_sel_err;
    logic        err_clr, err_sticky;
    logic [2:0]  sel;
    logic [31:0] b, out_data;
    logic [15:0] imm;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_sel_err64;
    logic        err_clr64, err_sticky64;
    logic [2:0]  sel64;
    logic [63:0] b64, out_data64;
    logic [15:0] imm64;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_sweep [8];

    always #5 clk = ~clk;

    alu_srcb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .b(b), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel_err(out_sel_err), .err_clr(err_clr),
        .err_sticky(err_sticky)
    );

    alu_srcb_stage #(.DATA_W(64), .IMM_W(16), .PC_INC(8)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .sel(sel64), .b(b64), .imm(imm64), .out_valid(out_valid64),
        .out_ready(out_ready64), .out_data(out_data64), .out_sel_err(out_sel_err64),
        .err_clr(err_clr64), .err_sticky(err_sticky64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_sweep[0] = 32'hDEADBEEF;
        exp_sweep[1] = 32'h00000004;
        exp_sweep[2] = 32'hFFFF8004;
        exp_sweep[3] = 32'hFFFE0010;
        exp_sweep[4] = 32'h00000001;
        exp_sweep[5] = 32'h00008004;
        exp_sweep[6] = 32'h80040000;
        exp_sweep[7] = 32'h00000000;

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
        sel = 3'd7; b = 32'hDEADBEEF; imm = 16'h8004;
        in_valid64 = 1'b0; out_ready64 = 1'b1; err_clr64 = 1'b0;
        sel64 = 3'd0; b64 = '0; imm64 = 16'hFFFF;

        // Reset with a reserved request presented: nothing may be accepted.
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_sel_err", {63'd0, out_sel_err}, 64'd0);
        chk("rst_sticky", {63'd0, err_sticky}, 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        step();
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_sticky", {63'd0, err_sticky}, 64'd0);

        // Decode sweep, back-to-back, each result one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; sel = 3'(i);
            step();
            chk($sformatf("sweep%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("sweep%0d_data", i), {32'd0, out_data}, {32'd0, exp_sweep[i]});
            chk($sformatf("sweep%0d_err", i), {63'd0, out_sel_err}, (i == 7) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        chk("sweep_sticky", {63'd0, err_sticky}, 64'd1);
        step();
        chk("sweep_drained", {63'd0, out_valid}, 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("sweep_clr", {63'd0, err_sticky}, 64'd0);

        // Backpressure: sel 4, 1, 0 with out_ready low.
        out_ready = 1'b0; b = 32'h12345678;
        in_valid = 1'b1; sel = 3'd4;
        step();
        chk("bp1_data", {32'd0, out_data}, 64'd1);
        chk("bp1_in_ready", {63'd0, in_ready}, 64'd1);
        sel = 3'd1;
        step();
        chk("bp2_data", {32'd0, out_data}, 64'd1);
        chk("bp2_in_ready", {63'd0, in_ready}, 64'd0);
        sel = 3'd0;
        step();
        chk("bp3_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp3_data", {32'd0, out_data}, 64'd1);

        // Stable hold while stalled, with b/imm wiggling.
        for (int i = 0; i < 5; i++) begin
            b = 32'h11110000 + 32'(i); imm = 16'h0100 + 16'(i);
            step();
            chk($sformatf("hold%0d_data", i), {32'd0, out_data}, 64'd1);
            chk($sformatf("hold%0d_valid", i), {63'd0, out_valid}, 64'd1);
        end
        b = 32'hCAFEF00D; imm = 16'h8004;

        // Release: skid entry (PC_INC) then the third request (b).
        out_ready = 1'b1;
        step();
        chk("rel1_data", {32'd0, out_data}, 64'd4);
        chk("rel1_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("rel2_data", {32'd0, out_data}, 64'hCAFEF00D);
        chk("rel2_valid", {63'd0, out_valid}, 64'd1);
        step();
        chk("rel3_empty", {63'd0, out_valid}, 64'd0);

        // Sticky error set / set-with-clear / clear.
        in_valid = 1'b1; sel = 3'd7;
        step();
        chk("stk_set", {63'd0, err_sticky}, 64'd1);
        chk("stk_out_err", {63'd0, out_sel_err}, 64'd1);
        chk("stk_out_data", {32'd0, out_data}, 64'd0);
        err_clr = 1'b1;
        step();
        chk("stk_set_wins", {63'd0, err_sticky}, 64'd1);
        in_valid = 1'b0;
        step();
        err_clr = 1'b0;
        chk("stk_cleared", {63'd0, err_sticky}, 64'd0);
        step();

        // Reset mid-operation with both entries full.
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd5;
        step();
        sel = 3'd7;
        step();
        chk("mid_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_sticky", {63'd0, err_sticky}, 64'd1);
        chk("mid_data", {32'd0, out_data}, 64'h00008004);
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_sticky", {63'd0, err_sticky}, 64'd0);
        chk("mid_rst_data", {32'd0, out_data}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_stale%0d", i), {63'd0, out_valid}, 64'd0);
        end

        // 64-bit instance with PC_INC=8.
        in_valid64 = 1'b1; imm64 = 16'hFFFF;
        sel64 = 3'd2;
        step();
        chk("p64_sext", out_data64, 64'hFFFF_FFFF_FFFF_FFFF);
        sel64 = 3'd3;
        step();
        chk("p64_sext_sl2", out_data64, 64'hFFFF_FFFF_FFFF_FFFC);
        sel64 = 3'd6;
        step();
        chk("p64_upper", out_data64, 64'hFFFF_0000_0000_0000);
        sel64 = 3'd1;
        step();
        chk("p64_pcinc", out_data64, 64'd8);
        chk("p64_valid", {63'd0, out_valid64}, 64'd1);
        chk("p64_err", {62'd0, out_sel_err64, err_sticky64}, 64'd0);
        in_valid64 = 1'b0;
        step();
        chk("p64_drained", {62'd0, out_valid64, in_ready64}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_srcb_stage.md
ALU_SRCB_STAGE -- requirements
Module: alu_srcb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width (>= IMM_W+2).
REQ-002 SHALL have parameter IMM_W, default 16, immediate field width.
REQ-003 SHALL have parameter PC_INC, default 4, constant driven for SEL_PCINC.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream operand request valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a request.
REQ-008 SHALL have port sel  input  3  operand-B select code.
REQ-009 SHALL have port b  input  DATA_W  B register value.
REQ-010 SHALL have port imm  input  IMM_W  raw instruction immediate.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  ALU consumes out_data.
REQ-013 SHALL have port out_data  output  DATA_W  selected operand B.
REQ-014 SHALL have port out_sel_err  output  1  current out_data came from reserved select.
REQ-015 SHALL have port err_clr  input  1  clears err_sticky.
REQ-016 SHALL have port err_sticky  output  1  a reserved select was ever accepted since clear.

Function
REQ-017 Select decode SHALL be: 0 b; 1 PC_INC; 2 sign-extend(imm); 3 sign-extend(imm)<<2; 4 constant 1; 5 zero-extend(imm); 6 imm<<(DATA_W-IMM_W) low bits zero; 7 reserved -> data 0, out_sel_err=1.
REQ-018 Extension and shift SHALL be computed to DATA_W bits; bits shifted past DATA_W are discarded.
REQ-019 A request SHALL be accepted on a cycle with in_valid && in_ready; its result SHALL appear on out_data with out_valid=1 exactly one cycle later when the output is empty or drains that cycle.
REQ-020 Handshake SHALL be a 2-entry skid buffer: output register plus one skid register; in_ready SHALL be registered and equal to !skid_valid.
REQ-021 When out_valid && !out_ready and a request is accepted, the result SHALL go to the skid register; in_ready SHALL drop the next cycle.
REQ-022 When out_ready && out_valid and skid is full, skid contents SHALL move to output next cycle and in_ready SHALL rise next cycle.
REQ-023 out_data, out_sel_err SHALL hold stable while out_valid && !out_ready.
REQ-024 Results SHALL leave in acceptance order; no request SHALL be dropped or duplicated.
REQ-025 err_sticky SHALL set the cycle after an accepted sel=7; err_clr SHALL clear it the cycle after; simultaneous set and clear SHALL leave it set.
REQ-026 in_valid with in_ready=0 SHALL have no effect; sel, b, imm SHALL be sampled only on acceptance.

Reset
REQ-027 On reset: out_valid=0, skid_valid=0, in_ready=1, out_data=0, out_sel_err=0, err_sticky=0.
REQ-028 Reset asserted mid-transfer SHALL discard both buffered entries; no result SHALL emerge after reset.
REQ-029 Requests presented during a reset cycle SHALL NOT be accepted.

Structure
REQ-030 Package alu_srcb_pkg SHALL hold the 3-bit select encoding enum (SEL_B, SEL_PCINC, SEL_SEXT, SEL_SEXT_SL2, SEL_ONE, SEL_ZEXT, SEL_UPPER, SEL_RSVD) and default parameter constants.
REQ-031 Decode SHALL be combinational in alu_srcb_stage; buffering SHALL be one sub-module alu_srcb_skid, parametrised on payload width (DATA_W+1).

Verification
REQ-032 Decode sweep, out_ready=1: b=0xDEADBEEF, imm=0x8004, sel 0..7 -> 0xDEADBEEF, 0x4, 0xFFFF8004, 0xFFFE0010, 0x1, 0x00008004, 0x80040000, 0x0 with out_sel_err only for 7, each one cycle after acceptance.
REQ-033 Backpressure: out_ready=0, three back-to-back requests sel=4,1,0 -> first on output, second in skid, in_ready=0 from cycle 2, third not accepted; release out_ready -> outputs 1,4,then b in order.
REQ-034 Stable hold: out_ready=0 for 5 cycles with changing b/imm -> out_data constant.
REQ-035 Sticky error: accept sel=7 -> err_sticky=1 next cycle; err_clr with another sel=7 same cycle -> remains 1; err_clr alone -> 0 next cycle.
REQ-036 Reset mid-operation: both entries full, assert reset one cycle -> out_valid=0, in_ready=1, err_sticky=0 next cycle; no stale data later.
REQ-037 Parametric: DATA_W=64, IMM_W=16, PC_INC=8, imm=0xFFFF, sel=2,3,6 -> 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FFFC, 0xFFFF_0000_0000_0000; sel=1 -> 8.
